// File: rtl/dht_uart_formatter_pkg.sv
// Shared definitions for the DHT reading-to-UART text formatter:
// FSM state encoding, record geometry and the ASCII bytes used in a record.
package dht_fmt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        CONV  = 2'd2,
        SEND  = 2'd3
    } fmt_state_t;

    localparam int FRAME_LEN   = 24;
    localparam int CONV_CYCLES = 36;

    localparam logic [7:0]  ASC_T   = 8'h54;
    localparam logic [7:0]  ASC_H   = 8'h48;
    localparam logic [7:0]  ASC_EQ  = 8'h3D;
    localparam logic [7:0]  ASC_DOT = 8'h2E;
    localparam logic [7:0]  ASC_0   = 8'h30;
    localparam logic [7:0]  ASC_CR  = 8'h0D;
    localparam logic [7:0]  ASC_LF  = 8'h0A;
    localparam logic [15:0] ASC_OK  = 16'h4F4B;
    localparam logic [15:0] ASC_ER  = 16'h4552;

    // One BCD digit to its ASCII character
    function automatic logic [7:0] digit_ascii(input logic [3:0] d);
        return ASC_0 + {4'd0, d};
    endfunction

endpackage

// File: rtl/dht_uart_formatter_bin2bcd8.sv
// Sequential double-dabble: 8-bit binary to three BCD digits.
// A start cycle loads the operand, then 8 shift-add-3 cycles follow;
// done pulses for one cycle once the digits are final (9 cycles total).
module bin2bcd8 (
    input  logic       clk_50M,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] bin,
    output logic       done,
    output logic [3:0] d2,
    output logic [3:0] d1,
    output logic [3:0] d0
);
    logic [7:0]  bin_reg;
    logic [11:0] bcd_reg;
    logic [3:0]  cnt_reg;
    logic        done_reg;
    logic [11:0] bcd_adj;

    // Add 3 to every digit that is 5 or more before the next shift
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                        (bcd_reg[gi*4 +: 4] + 4'd3) :
                                        bcd_reg[gi*4 +: 4];
        end
    endgenerate

    // Load on start, then shift the operand into the BCD register bit by bit
    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            bin_reg  <= '0;
            bcd_reg  <= '0;
            cnt_reg  <= '0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (start) begin
                bin_reg <= bin;
                bcd_reg <= '0;
                cnt_reg <= 4'd8;
            end else if (cnt_reg != 4'd0) begin
                {bcd_reg, bin_reg} <= {bcd_adj[10:0], bin_reg, 1'b0};
                cnt_reg            <= cnt_reg - 4'd1;
                done_reg           <= (cnt_reg == 4'd1);
            end
        end
    end

    assign done = done_reg;
    assign d2   = bcd_reg[11:8];
    assign d1   = bcd_reg[7:4];
    assign d0   = bcd_reg[3:0];

endmodule

// File: rtl/dht_uart_formatter.sv
// Formats one DHT reading into the 24-byte text record
// "T=ddd.ddd H=ddd.ddd OK\r\n" and streams it over a valid/ready byte link.
// Optional build macro DHT_FMT_DROP_BAD_EN: records with a bad checksum are
// discarded after the crc_err pulse instead of being emitted with tag "ER".
module dht_uart_formatter
    import dht_fmt_pkg::*;
#(
    parameter logic [7:0] SEP_CHAR   = 8'h20,
    parameter int         DROP_CNT_W = 8
) (
    input  logic                  clk_50M,
    input  logic                  reset,
    input  logic [7:0]            T_integral,
    input  logic [7:0]            T_decimal,
    input  logic [7:0]            RH_integral,
    input  logic [7:0]            RH_decimal,
    input  logic [7:0]            Checksum,
    input  logic                  data_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  crc_err,
    output logic [DROP_CNT_W-1:0] drop_count
);
    fmt_state_t            state_reg;
    logic [7:0]            t_i_reg, t_d_reg, rh_i_reg, rh_d_reg, cks_reg;
    logic                  ok_reg;
    logic [5:0]            conv_cnt_reg;
    logic [3:0]            phase_reg;
    logic [1:0]            conv_idx_reg;
    logic [1:0]            cap_idx_reg;
    logic [11:0]           bcd_store_reg [4];
    logic [4:0]            send_idx_reg;
    logic [7:0]            tx_data_reg;
    logic                  tx_valid_reg, busy_reg, frame_done_reg;
    logic [DROP_CNT_W-1:0] drop_cnt_reg;

    logic                  ok_chk;
    logic [7:0]            bcd_bin;
    logic                  bcd_start, bcd_done;
    logic [3:0]            bcd_d2, bcd_d1, bcd_d0;
    logic [4:0]            next_idx;
    logic [7:0]            byte_next;
    logic [15:0]           tag;

    // Checksum over the latched bytes, 8-bit wrapping sum
    assign ok_chk = ((t_i_reg + t_d_reg + rh_i_reg + rh_d_reg) == cks_reg);

    // Select the operand of the conversion currently running
    always_comb begin
        bcd_bin = t_i_reg;
        case (conv_idx_reg)
            2'd0:    bcd_bin = t_i_reg;
            2'd1:    bcd_bin = t_d_reg;
            2'd2:    bcd_bin = rh_i_reg;
            default: bcd_bin = rh_d_reg;
        endcase
    end

    assign bcd_start = (state_reg == CONV) && (phase_reg == 4'd0);

    bin2bcd8 u_bcd (
        .clk_50M (clk_50M),
        .reset   (reset),
        .start   (bcd_start),
        .bin     (bcd_bin),
        .done    (bcd_done),
        .d2      (bcd_d2),
        .d1      (bcd_d1),
        .d0      (bcd_d0)
    );

    // Store each finished conversion; the last one lands early in SEND,
    // well before its digits are first needed at byte 16
    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) bcd_store_reg[i] <= '0;
            cap_idx_reg <= '0;
        end else if (state_reg == IDLE) begin
            cap_idx_reg <= '0;
        end else if (bcd_done) begin
            bcd_store_reg[cap_idx_reg] <= {bcd_d2, bcd_d1, bcd_d0};
            cap_idx_reg                <= cap_idx_reg + 2'd1;
        end
    end

    // Record byte for the index about to be presented
    assign next_idx = send_idx_reg + 5'd1;
    assign tag      = ok_reg ? ASC_OK : ASC_ER;

    always_comb begin
        byte_next = 8'h00;
        case (next_idx)
            5'd0:    byte_next = ASC_T;
            5'd1:    byte_next = ASC_EQ;
            5'd2:    byte_next = digit_ascii(bcd_store_reg[0][11:8]);
            5'd3:    byte_next = digit_ascii(bcd_store_reg[0][7:4]);
            5'd4:    byte_next = digit_ascii(bcd_store_reg[0][3:0]);
            5'd5:    byte_next = ASC_DOT;
            5'd6:    byte_next = digit_ascii(bcd_store_reg[1][11:8]);
            5'd7:    byte_next = digit_ascii(bcd_store_reg[1][7:4]);
            5'd8:    byte_next = digit_ascii(bcd_store_reg[1][3:0]);
            5'd9:    byte_next = SEP_CHAR;
            5'd10:   byte_next = ASC_H;
            5'd11:   byte_next = ASC_EQ;
            5'd12:   byte_next = digit_ascii(bcd_store_reg[2][11:8]);
            5'd13:   byte_next = digit_ascii(bcd_store_reg[2][7:4]);
            5'd14:   byte_next = digit_ascii(bcd_store_reg[2][3:0]);
            5'd15:   byte_next = ASC_DOT;
            5'd16:   byte_next = digit_ascii(bcd_store_reg[3][11:8]);
            5'd17:   byte_next = digit_ascii(bcd_store_reg[3][7:4]);
            5'd18:   byte_next = digit_ascii(bcd_store_reg[3][3:0]);
            5'd19:   byte_next = SEP_CHAR;
            5'd20:   byte_next = tag[15:8];
            5'd21:   byte_next = tag[7:0];
            5'd22:   byte_next = ASC_CR;
            5'd23:   byte_next = ASC_LF;
            default: byte_next = 8'h00;
        endcase
    end

    // Main record FSM with registered handshake and status outputs
    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            t_i_reg        <= '0;
            t_d_reg        <= '0;
            rh_i_reg       <= '0;
            rh_d_reg       <= '0;
            cks_reg        <= '0;
            ok_reg         <= 1'b0;
            conv_cnt_reg   <= '0;
            phase_reg      <= '0;
            conv_idx_reg   <= '0;
            send_idx_reg   <= '0;
            tx_data_reg    <= '0;
            tx_valid_reg   <= 1'b0;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (data_valid) begin
                        t_i_reg   <= T_integral;
                        t_d_reg   <= T_decimal;
                        rh_i_reg  <= RH_integral;
                        rh_d_reg  <= RH_decimal;
                        cks_reg   <= Checksum;
                        busy_reg  <= 1'b1;
                        state_reg <= CHECK;
                    end
                end
                CHECK: begin
                    ok_reg       <= ok_chk;
                    conv_cnt_reg <= '0;
                    phase_reg    <= '0;
                    conv_idx_reg <= '0;
`ifdef DHT_FMT_DROP_BAD_EN
                    if (!ok_chk) begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        state_reg <= CONV;
                    end
`else
                    state_reg <= CONV;
`endif
                end
                CONV: begin
                    conv_cnt_reg <= conv_cnt_reg + 6'd1;
                    if (phase_reg == 4'd8) begin
                        phase_reg    <= '0;
                        conv_idx_reg <= conv_idx_reg + 2'd1;
                    end else begin
                        phase_reg <= phase_reg + 4'd1;
                    end
                    if (conv_cnt_reg == 6'(CONV_CYCLES - 1)) begin
                        send_idx_reg <= '0;
                        tx_data_reg  <= ASC_T;
                        tx_valid_reg <= 1'b1;
                        state_reg    <= SEND;
                    end
                end
                SEND: begin
                    if (tx_valid_reg && tx_ready) begin
                        if (send_idx_reg == 5'(FRAME_LEN - 1)) begin
                            tx_valid_reg   <= 1'b0;
                            frame_done_reg <= 1'b1;
                            busy_reg       <= 1'b0;
                            state_reg      <= IDLE;
                        end else begin
                            send_idx_reg <= next_idx;
                            tx_data_reg  <= byte_next;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Count strobes that arrive while a record is in progress, saturating
    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            drop_cnt_reg <= '0;
        end else if (data_valid && (state_reg != IDLE) &&
                     (drop_cnt_reg != {DROP_CNT_W{1'b1}})) begin
            drop_cnt_reg <= drop_cnt_reg + 1'b1;
        end
    end

    assign tx_data    = tx_data_reg;
    assign tx_valid   = tx_valid_reg;
    assign busy       = busy_reg;
    assign frame_done = frame_done_reg;
    assign crc_err    = (state_reg == CHECK) && !ok_chk;
    assign drop_count = drop_cnt_reg;

endmodule

// File: tb/tb_dht_uart_formatter.sv
// Bench for dht_uart_formatter: expected record bytes are queued when a
// reading is driven and compared against the bytes the DUT hands over.
module tb_dht_uart_formatter;

    logic       clk_50M = 1'b0;
    logic       reset;
    logic [7:0] t_i, t_d, rh_i, rh_d, cks;
    logic       data_valid, data_valid2, tx_ready;
    logic [7:0] tx_data, tx_data2;
    logic       tx_valid, busy, frame_done, crc_err;
    logic       tx_valid2, busy2, frame_done2, crc_err2;
    logic [7:0] drop_count;
    logic [1:0] drop_count2;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q [$];
    logic [7:0] rx_q  [$];
    int         fd_cnt  = 0;
    int         fd_at   = -1;
    int         crc_cnt = 0;

    always #10 clk_50M = ~clk_50M;

    dht_uart_formatter dut (
        .clk_50M    (clk_50M),
        .reset      (reset),
        .T_integral (t_i),
        .T_decimal  (t_d),
        .RH_integral(rh_i),
        .RH_decimal (rh_d),
        .Checksum   (cks),
        .data_valid (data_valid),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .frame_done (frame_done),
        .crc_err    (crc_err),
        .drop_count (drop_count)
    );

    dht_uart_formatter #(.DROP_CNT_W(2)) dut2 (
        .clk_50M    (clk_50M),
        .reset      (reset),
        .T_integral (t_i),
        .T_decimal  (t_d),
        .RH_integral(rh_i),
        .RH_decimal (rh_d),
        .Checksum   (cks),
        .data_valid (data_valid2),
        .tx_data    (tx_data2),
        .tx_valid   (tx_valid2),
        .tx_ready   (tx_ready),
        .busy       (busy2),
        .frame_done (frame_done2),
        .crc_err    (crc_err2),
        .drop_count (drop_count2)
    );

    // Collect every transferred byte and the status pulses
    always @(negedge clk_50M) begin
        if (tx_valid && tx_ready) rx_q.push_back(tx_data);
        if (frame_done) begin
            fd_cnt++;
            fd_at = rx_q.size();
        end
        if (crc_err) crc_cnt++;
    end

    function automatic void push_dec(input logic [7:0] v);
        exp_q.push_back(8'h30 + 8'(v / 100));
        exp_q.push_back(8'h30 + 8'((v / 10) % 10));
        exp_q.push_back(8'h30 + 8'(v % 10));
    endfunction

    // Reference record for one reading
    function automatic void push_exp(input logic [7:0] ti, td, rhi, rhd, ck);
        logic [7:0] sum;
        sum = ti + td + rhi + rhd;
        exp_q.push_back(8'h54); exp_q.push_back(8'h3D);
        push_dec(ti); exp_q.push_back(8'h2E); push_dec(td);
        exp_q.push_back(8'h20);
        exp_q.push_back(8'h48); exp_q.push_back(8'h3D);
        push_dec(rhi); exp_q.push_back(8'h2E); push_dec(rhd);
        exp_q.push_back(8'h20);
        if (sum == ck) begin exp_q.push_back(8'h4F); exp_q.push_back(8'h4B); end
        else begin exp_q.push_back(8'h45); exp_q.push_back(8'h52); end
        exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    endfunction

    // One data_valid strobe; returns one tick after the sampling edge
    task automatic drive_dv(input logic [7:0] ti, td, rhi, rhd, ck, input bit both);
        @(posedge clk_50M); #1;
        t_i = ti; t_d = td; rh_i = rhi; rh_d = rhd; cks = ck;
        data_valid = 1'b1; data_valid2 = both;
        @(posedge clk_50M); #1;
        data_valid = 1'b0; data_valid2 = 1'b0;
    endtask

    task automatic pulse_dv(input bit a, input bit b);
        @(posedge clk_50M); #1;
        t_i = 8'($urandom); cks = 8'($urandom);
        data_valid = a; data_valid2 = b;
        @(posedge clk_50M); #1;
        data_valid = 1'b0; data_valid2 = 1'b0;
    endtask

    task automatic wait_frame(input int fd_before, output bit got);
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk_50M); #1;
            if (fd_cnt > fd_before) begin got = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; data_valid = 0; data_valid2 = 0; tx_ready = 1'b1;
        t_i = 0; t_d = 0; rh_i = 0; rh_d = 0; cks = 0;
        repeat (3) @(posedge clk_50M);
        #1 reset = 1'b0;
        @(posedge clk_50M); #1;
        total += 7;
        if (tx_valid !== 1'b0)     begin bad++; $display("FAIL rst_tx_valid got=%b exp=0", tx_valid); end
        if (tx_data !== 8'h00)     begin bad++; $display("FAIL rst_tx_data got=%h exp=00", tx_data); end
        if (busy !== 1'b0)         begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        if (frame_done !== 1'b0)   begin bad++; $display("FAIL rst_frame_done got=%b exp=0", frame_done); end
        if (crc_err !== 1'b0)      begin bad++; $display("FAIL rst_crc_err got=%b exp=0", crc_err); end
        if (drop_count !== 8'd0)   begin bad++; $display("FAIL rst_drop got=%0d exp=0", drop_count); end
        if (drop_count2 !== 2'd0)  begin bad++; $display("FAIL rst_drop2 got=%0d exp=0", drop_count2); end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        int base, fd0, crc0, lat; bit got; logic [7:0] g, e;
        base = rx_q.size(); fd0 = fd_cnt; crc0 = crc_cnt; lat = -1;
        push_exp(23, 5, 55, 15, 98);
        drive_dv(23, 5, 55, 15, 98, 0);
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk_50M); #1;
            if (tx_valid) begin lat = k; break; end
        end
        total += 2;
        if (lat != 37) begin bad++; $display("FAIL basic_latency got=%0d exp=37", lat); end
        if (tx_data !== 8'h54) begin bad++; $display("FAIL basic_first got=%h exp=54", tx_data); end
        wait_frame(fd0, got);
        total += 3;
        if (!got) begin bad++; $display("FAIL basic_frame_done got=none exp=pulse"); end
        if (fd_at - base != 24) begin bad++; $display("FAIL basic_fd_pos got=%0d exp=24", fd_at - base); end
        if (crc_cnt != crc0) begin bad++; $display("FAIL basic_crc got=%0d exp=%0d", crc_cnt, crc0); end
        for (int k = 0; k < 24; k++) begin
            g = (base + k < rx_q.size()) ? rx_q[base + k] : 8'hxx;
            e = exp_q.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL basic_byte%0d got=%h exp=%h", k, g, e); end
        end
        $display("test_basic done: %0d bytes", rx_q.size() - base);
    endtask

    task automatic test_crc();
        int base, fd0, crc0; logic [7:0] g, e;
        base = rx_q.size(); fd0 = fd_cnt; crc0 = crc_cnt;
`ifndef DHT_FMT_DROP_BAD_EN
        push_exp(29, 1, 30, 5, 66);
`endif
        drive_dv(29, 1, 30, 5, 66, 0);
        total += 2;
        if (crc_err !== 1'b1) begin bad++; $display("FAIL crc_pulse got=%b exp=1", crc_err); end
        if (busy !== 1'b1) begin bad++; $display("FAIL crc_busy_check got=%b exp=1", busy); end
`ifdef DHT_FMT_DROP_BAD_EN
        begin
            int seen;
            seen = 0;
            @(posedge clk_50M); #1;
            total++;
            if (busy !== 1'b0) begin bad++; $display("FAIL crc_drop_busy got=%b exp=0", busy); end
            for (int k = 0; k < 60; k++) begin
                @(posedge clk_50M); #1;
                if (tx_valid) seen++;
            end
            total += 3;
            if (seen != 0) begin bad++; $display("FAIL crc_drop_txvalid got=%0d exp=0", seen); end
            if (crc_cnt != crc0 + 1) begin bad++; $display("FAIL crc_count got=%0d exp=%0d", crc_cnt, crc0 + 1); end
            if (drop_count !== 8'd0) begin bad++; $display("FAIL crc_drop_cnt got=%0d exp=0", drop_count); end
        end
`else
        begin
            bit got;
            wait_frame(fd0, got);
            total += 2;
            if (!got) begin bad++; $display("FAIL crc_frame got=none exp=pulse"); end
            if (crc_cnt != crc0 + 1) begin bad++; $display("FAIL crc_count got=%0d exp=%0d", crc_cnt, crc0 + 1); end
            for (int k = 0; k < 24; k++) begin
                g = (base + k < rx_q.size()) ? rx_q[base + k] : 8'hxx;
                e = exp_q.pop_front(); total++;
                if (g !== e) begin bad++; $display("FAIL crc_byte%0d got=%h exp=%h", k, g, e); end
            end
        end
`endif
        $display("test_crc done: crc pulses=%0d", crc_cnt - crc0);
    endtask

    task automatic test_extremes();
        logic [7:0] vals [2]; logic [7:0] cks_t [2];
        int base, fd0; bit got; logic [7:0] g, e;
        vals[0] = 8'd255; cks_t[0] = 8'd252;
        vals[1] = 8'd0;   cks_t[1] = 8'd0;
        for (int r = 0; r < 2; r++) begin
            base = rx_q.size(); fd0 = fd_cnt;
            push_exp(vals[r], vals[r], vals[r], vals[r], cks_t[r]);
            drive_dv(vals[r], vals[r], vals[r], vals[r], cks_t[r], 0);
            wait_frame(fd0, got);
            total++;
            if (!got) begin bad++; $display("FAIL ext%0d_frame got=none exp=pulse", r); end
            for (int k = 0; k < 24; k++) begin
                g = (base + k < rx_q.size()) ? rx_q[base + k] : 8'hxx;
                e = exp_q.pop_front(); total++;
                if (g !== e) begin bad++; $display("FAIL ext%0d_byte%0d got=%h exp=%h", r, k, g, e); end
            end
            $display("test_extremes record %0d value=%0d done", r, vals[r]);
        end
    endtask

    task automatic test_stall();
        int base, fd0, seen; bit got; logic [7:0] g, e;
        base = rx_q.size(); fd0 = fd_cnt; seen = 0;
        push_exp(12, 34, 56, 78, 180);
        tx_ready = 1'b0;
        drive_dv(12, 34, 56, 78, 180, 0);
        for (int k = 0; k < 80; k++) begin
            @(posedge clk_50M); #1;
            if (tx_valid) begin seen = 1; break; end
        end
        total++;
        if (seen == 0) begin bad++; $display("FAIL stall_start got=no_valid exp=valid"); end
        tx_ready = 1'b1;
        repeat (5) @(posedge clk_50M);
        #1 tx_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_50M);
            total++;
            if (!(tx_valid === 1'b1 && tx_data === 8'h2E)) begin
                bad++; $display("FAIL stall_hold%0d got=%b/%h exp=1/2e", k, tx_valid, tx_data);
            end
        end
        @(posedge clk_50M); #1 tx_ready = 1'b1;
        wait_frame(fd0, got);
        total += 2;
        if (!got) begin bad++; $display("FAIL stall_frame got=none exp=pulse"); end
        if (fd_at - base != 24) begin bad++; $display("FAIL stall_len got=%0d exp=24", fd_at - base); end
        for (int k = 0; k < 24; k++) begin
            g = (base + k < rx_q.size()) ? rx_q[base + k] : 8'hxx;
            e = exp_q.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL stall_byte%0d got=%h exp=%h", k, g, e); end
        end
        $display("test_stall done");
    endtask

    task automatic test_overrun();
        int base, fd0; bit got; logic [7:0] g, e;
        base = rx_q.size(); fd0 = fd_cnt;
        push_exp(40, 2, 60, 7, 109);
        drive_dv(40, 2, 60, 7, 109, 1);
        repeat (40) @(posedge clk_50M);
        for (int p = 0; p < 3; p++) pulse_dv(1, 1);
        total += 2;
        if (drop_count !== 8'd3) begin bad++; $display("FAIL ovr_drop got=%0d exp=3", drop_count); end
        if (drop_count2 !== 2'd3) begin bad++; $display("FAIL ovr_drop2 got=%0d exp=3", drop_count2); end
        for (int p = 0; p < 2; p++) pulse_dv(0, 1);
        total += 2;
        if (drop_count2 !== 2'd3) begin bad++; $display("FAIL ovr_sat got=%0d exp=3", drop_count2); end
        if (drop_count !== 8'd3) begin bad++; $display("FAIL ovr_drop_hold got=%0d exp=3", drop_count); end
        wait_frame(fd0, got);
        total++;
        if (!got) begin bad++; $display("FAIL ovr_frame got=none exp=pulse"); end
        for (int k = 0; k < 24; k++) begin
            g = (base + k < rx_q.size()) ? rx_q[base + k] : 8'hxx;
            e = exp_q.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL ovr_byte%0d got=%h exp=%h", k, g, e); end
        end
        $display("test_overrun done: drop=%0d drop2=%0d", drop_count, drop_count2);
    endtask

    task automatic test_reset_mid();
        int base, fd0, reached; bit got; logic [7:0] g, e;
        base = rx_q.size(); fd0 = fd_cnt; reached = 0;
        drive_dv(1, 2, 3, 4, 10, 0);
        for (int k = 0; k < 200; k++) begin
            @(posedge clk_50M); #1;
            if (rx_q.size() - base == 12) begin reached = 1; break; end
        end
        total++;
        if (reached == 0) begin bad++; $display("FAIL rmid_reach got=%0d exp=12", rx_q.size() - base); end
        reset = 1'b1;
        #1;
        total += 2;
        if (tx_valid !== 1'b0) begin bad++; $display("FAIL rmid_txvalid got=%b exp=0", tx_valid); end
        if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        repeat (3) @(posedge clk_50M);
        #1 reset = 1'b0;
        repeat (30) @(posedge clk_50M);
        #1;
        total += 2;
        if (fd_cnt != fd0) begin bad++; $display("FAIL rmid_no_fd got=%0d exp=%0d", fd_cnt, fd0); end
        if (rx_q.size() - base != 12) begin bad++; $display("FAIL rmid_bytes got=%0d exp=12", rx_q.size() - base); end
        base = rx_q.size();
        push_exp(23, 5, 55, 15, 98);
        drive_dv(23, 5, 55, 15, 98, 0);
        wait_frame(fd0, got);
        total++;
        if (!got) begin bad++; $display("FAIL rmid_frame got=none exp=pulse"); end
        for (int k = 0; k < 24; k++) begin
            g = (base + k < rx_q.size()) ? rx_q[base + k] : 8'hxx;
            e = exp_q.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL rmid_byte%0d got=%h exp=%h", k, g, e); end
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_crc();
        test_extremes();
        test_stall();
        test_overrun();
        test_reset_mid();
        repeat (3) @(posedge clk_50M);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
